// File: rtl/req_pkg.sv
// Shared types and defaults for the request initiator and its cycle timer.
package req_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam int TIMEOUT_CYCLES_DEF = 16;

    // Wide enough for the largest legal timeout (255) and any hold count (15).
    localparam int TIMER_W = 8;

endpackage

// File: rtl/req_cycle_timer.sv
// Loadable down-counter with a zero flag; shared by the grant-wait timeout and the hold count.
module req_cycle_timer
    import req_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over enable; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/req_initiator.sv
// Request/grant initiator: raises req, waits for gnt or a timeout, holds, releases,
// then reports done or timeout for one cycle. All outputs are registers.
module req_initiator
    import req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       hold_cycles,
    input  logic             gnt,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] grant_count
);

    // Timer counts down to zero, so load one less than the number of wait edges.
    localparam logic [TIMER_W-1:0] TO_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    logic [3:0]         hold_q;
    logic               abort;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                end
            end
            REQ: begin
                if (gnt) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(hold_q);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            HOLD:    tmr_en = 1'b1;
            default: ;
        endcase
    end

    req_cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            grant_count <= '0;
            hold_q      <= '0;
            abort       <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hold_q <= hold_cycles;
                        abort  <= 1'b0;
                        req    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // A grant seen on the expiry edge still counts as a grant.
                    if (gnt) begin
                        state <= HOLD;
                        if (grant_count != CNT_MAX) begin
                            grant_count <= grant_count + CNT_W'(1);
                        end
                    end else if (tmr_zero) begin
                        req   <= 1'b0;
                        abort <= 1'b1;
                        state <= RELEASE;
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        req   <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!gnt) begin
                        state <= FINISH;
                        if (abort) begin
                            timeout <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator with a one-cycle registered responder (gnt <= req).
module tb_req_initiator;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       hold_cycles;
    logic             gnt;
    logic             req;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] grant_count;

    // gmode 0: responder echoes req one cycle late; 1: gnt tied low; 2: gnt = gnt_force
    int   gmode;
    logic gnt_force;
    logic gnt_reg;

    int errors = 0;
    int checks = 0;
    int base_req_hi;

    always #5 clk = ~clk;

    always @(posedge clk) gnt_reg <= req;

    always_comb begin
        gnt = gnt_reg;
        if (gmode == 1) gnt = 1'b0;
        else if (gmode == 2) gnt = gnt_force;
    end

    req_initiator #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .gnt         (gnt),
        .req         (req),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .grant_count (grant_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller raises start; index 0 is the edge that accepts it. Stops once busy drops.
    task automatic observe(input int maxc, output int req_hi, output int done_n,
                           output int done_at, output int to_n, output int to_at,
                           output int idle_at);
        req_hi = 0; done_n = 0; done_at = -1; to_n = 0; to_at = -1; idle_at = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (req) req_hi++;
            if (done) begin done_n++; done_at = i; end
            if (timeout) begin to_n++; to_at = i; end
            if (!busy) begin idle_at = i; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; hold_cycles = 4'd0; gmode = 2; gnt_force = 1'b1;
        step(); step();
        checks += 5;
        if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        if (grant_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", grant_count); end
        rst = 1'b0; start = 1'b0;
        step(); step(); step();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_gnt_busy: got %b expected 0", busy); end
        if (grant_count !== '0) begin errors++; $display("FAIL idle_gnt_count: got %0d expected 0", grant_count); end
        gnt_force = 1'b0; gmode = 0;
        step(); step();
    endtask

    task automatic test_basic();
        int rh, dn, da, tn, ta, ia;
        hold_cycles = 4'd0; start = 1'b1;
        observe(40, rh, dn, da, tn, ta, ia);
        base_req_hi = rh;
        checks += 6;
        if (rh != 3) begin errors++; $display("FAIL basic_req_cycles: got %0d expected 3", rh); end
        if (dn != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
        if (da != 5) begin errors++; $display("FAIL basic_done_at: got %0d expected 5", da); end
        if (tn != 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", tn); end
        if (ia != 6) begin errors++; $display("FAIL basic_idle_at: got %0d expected 6", ia); end
        if (grant_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", grant_count); end
        step(); step();
    endtask

    task automatic test_hold();
        int rh, dn, da, tn, ta, ia;
        hold_cycles = 4'd3; start = 1'b1;
        observe(40, rh, dn, da, tn, ta, ia);
        checks += 6;
        if (rh - base_req_hi != 3) begin errors++; $display("FAIL hold_extra_cycles: got %0d expected 3", rh - base_req_hi); end
        if (rh != 6) begin errors++; $display("FAIL hold_req_cycles: got %0d expected 6", rh); end
        if (dn != 1) begin errors++; $display("FAIL hold_done_count: got %0d expected 1", dn); end
        if (da != 8) begin errors++; $display("FAIL hold_done_at: got %0d expected 8", da); end
        if (ia != 9) begin errors++; $display("FAIL hold_idle_at: got %0d expected 9", ia); end
        if (grant_count !== 8'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", grant_count); end
        hold_cycles = 4'd0;
        step(); step();
    endtask

    task automatic test_timeout();
        int rh, dn, da, tn, ta, ia;
        gmode = 1; hold_cycles = 4'd0; start = 1'b1;
        observe(60, rh, dn, da, tn, ta, ia);
        checks += 6;
        if (rh != 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", rh); end
        if (tn != 1) begin errors++; $display("FAIL to_pulse_count: got %0d expected 1", tn); end
        if (ta != 17) begin errors++; $display("FAIL to_pulse_at: got %0d expected 17", ta); end
        if (dn != 0) begin errors++; $display("FAIL to_done: got %0d expected 0", dn); end
        if (ia != 18) begin errors++; $display("FAIL to_idle_at: got %0d expected 18", ia); end
        if (grant_count !== 8'd2) begin errors++; $display("FAIL to_count: got %0d expected 2", grant_count); end
        gmode = 0;
        step(); step();
    endtask

    task automatic test_grant_at_expiry();
        int rh = 0, dn = 0, da = -1, tn = 0;
        logic req16 = 1'b0;
        gmode = 2; gnt_force = 1'b0; hold_cycles = 4'd0; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (i == 15) gnt_force = 1'b1;
            if (i == 16) begin gnt_force = 1'b0; req16 = req; end
            if (req) rh++;
            if (done) begin dn++; da = i; end
            if (timeout) tn++;
        end
        checks += 5;
        if (req16 !== 1'b1) begin errors++; $display("FAIL expiry_req_held: got %b expected 1", req16); end
        if (tn != 0) begin errors++; $display("FAIL expiry_timeout: got %0d expected 0", tn); end
        if (dn != 1) begin errors++; $display("FAIL expiry_done_count: got %0d expected 1", dn); end
        if (da != 18) begin errors++; $display("FAIL expiry_done_at: got %0d expected 18", da); end
        if (grant_count !== 8'd3) begin errors++; $display("FAIL expiry_count: got %0d expected 3", grant_count); end
        gmode = 0;
        step(); step();
    endtask

    task automatic test_back_to_back();
        int rises = 0, dn = 0, last = -1, bad = 0, both = 0, cnt100 = -1;
        logic pbusy = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        hold_cycles = 4'd0; start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (busy && !pbusy) rises++;
            pbusy = busy;
            if (done && timeout) both++;
            if (done) begin
                dn++;
                if (last >= 0 && i - last != 7) bad++;
                last = i;
                if (dn == 100) cnt100 = int'(grant_count);
                if (dn == 300) break;
            end
        end
        start = 1'b0;
        checks += 6;
        if (dn != 300) begin errors++; $display("FAIL b2b_done_count: got %0d expected 300", dn); end
        if (rises != 300) begin errors++; $display("FAIL b2b_txn_starts: got %0d expected 300", rises); end
        if (bad != 0) begin errors++; $display("FAIL b2b_period: got %0d bad intervals expected 0", bad); end
        if (both != 0) begin errors++; $display("FAIL b2b_done_and_timeout: got %0d expected 0", both); end
        if (cnt100 != 100) begin errors++; $display("FAIL b2b_count_100: got %0d expected 100", cnt100); end
        if (grant_count !== 8'd255) begin errors++; $display("FAIL b2b_saturate: got %0d expected 255", grant_count); end
        step(); step(); step();
    endtask

    task automatic test_reset_in_hold();
        int dn = 0, tn = 0, bz = 0;
        hold_cycles = 4'd5; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        checks += 2;
        if (req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rsthold_pre: got req=%b busy=%b expected 1 1", req, busy); end
        if (grant_count !== 8'd255) begin errors++; $display("FAIL rsthold_pre_count: got %0d expected 255", grant_count); end
        rst = 1'b1; step(); rst = 1'b0;
        checks += 4;
        if (req !== 1'b0) begin errors++; $display("FAIL rsthold_req: got %b expected 0", req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rsthold_busy: got %b expected 0", busy); end
        if (grant_count !== '0) begin errors++; $display("FAIL rsthold_count: got %0d expected 0", grant_count); end
        if (done !== 1'b0) begin errors++; $display("FAIL rsthold_done: got %b expected 0", done); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dn++;
            if (timeout) tn++;
            if (busy) bz++;
        end
        checks += 1;
        if (dn != 0 || tn != 0 || bz != 0) begin
            errors++;
            $display("FAIL rsthold_after: got done=%0d timeout=%0d busy=%0d expected 0 0 0", dn, tn, bz);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold_cycles = 4'd0; gmode = 0; gnt_force = 1'b0;
        base_req_hi = 0;
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_grant_at_expiry();
        test_back_to_back();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
